regfile: RTL and testbench

// - Architectural integer register file (x0..x31) serving the ID stage's two read requests and the WB stage's write.
// - Read ports are combinational, so ID sees data in the same cycle. A same-cycle WB write is bypassed to the read outputs.
// - After reset, a sequential sweep clears x1..x31 one register per cycle. The block holds the pipeline through stall_from_reg until the sweep is done.

---
 rtl/regfile.sv | 146 ++++++++++++++
 tb/tb_regfile.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
// Module   : regfile
// Purpose  : Architectural integer register file x0..x31. Two combinational
//            read ports for ID with same-cycle bypass of the WB write, one
//            write port for WB. After reset the array is cleared and the
//            pipeline is held through stall_from_reg until clearing is done.
// Config   : REGFILE_FAST_INIT_EN - when defined, the array clears in parallel
//            while reset is held and the CLEAR sweep state is skipped.
//            Default (undefined): one register cleared per ready cycle.
// Revision : 1.0 - initial release
// ============================================================================
module regfile #(
    parameter int REG_NUM = 32,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              reg1_reador_not,
    input  logic [ADDR_W-1:0] reg1addr,
    output logic [DATA_W-1:0] reg1_data,
    input  logic              reg2_reador_not,
    input  logic [ADDR_W-1:0] reg2addr,
    output logic [DATA_W-1:0] reg2_data,
    input  logic              write_rsd_in,
    input  logic [ADDR_W-1:0] rsd_addr_in,
    input  logic [DATA_W-1:0] rsd_data_in,
    output logic              stall_from_reg
);

    localparam logic [1:0] c_ST_RESET = 2'd0;
    localparam logic [1:0] c_ST_CLEAR = 2'd1;
    localparam logic [1:0] c_ST_READY = 2'd2;

    localparam logic [ADDR_W-1:0] c_ZERO_ADDR = '0;

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_mem [0:REG_NUM-1];

    logic              w_wr_en;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    // A WB write is architecturally effective only when ready and not to x0.
    assign w_wr_en = (r_state == c_ST_READY) && rdy_in && write_rsd_in
                     && (rsd_addr_in != c_ZERO_ADDR);

`ifdef REGFILE_FAST_INIT_EN

    // Control FSM: reset goes straight to READY, the array is cleared during reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state <= c_ST_RESET;
        end else if (rdy_in) begin
            case (r_state)
                c_ST_RESET: r_state <= c_ST_READY;
                c_ST_READY: r_state <= c_ST_READY;
                default:    r_state <= c_ST_RESET;
            endcase
        end
    end

    // Storage: parallel clear of x1..x31 while reset is held, WB writes in READY.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 1; i < REG_NUM; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[rsd_addr_in] <= rsd_data_in;
        end
    end

`else

    localparam logic [ADDR_W-1:0] c_FIRST_IDX = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_LAST_IDX  = ADDR_W'(REG_NUM - 1);

    logic [ADDR_W-1:0] r_clr_ptr;

    // Control FSM and sweep pointer; rdy_in low freezes both.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state   <= c_ST_RESET;
            r_clr_ptr <= c_FIRST_IDX;
        end else if (rdy_in) begin
            case (r_state)
                c_ST_RESET: r_state <= c_ST_CLEAR;
                c_ST_CLEAR: begin
                    if (r_clr_ptr == c_LAST_IDX) begin
                        // Last register cleared: stop here rather than wrap.
                        r_state   <= c_ST_READY;
                        r_clr_ptr <= c_FIRST_IDX;
                    end else begin
                        r_clr_ptr <= r_clr_ptr + c_FIRST_IDX;
                    end
                end
                c_ST_READY: r_state <= c_ST_READY;
                default:    r_state <= c_ST_RESET;
            endcase
        end
    end

    // Storage: one register cleared per ready cycle in CLEAR, WB writes in READY.
    always_ff @(posedge clk_in) begin
        if (rst_in && rdy_in && (r_state == c_ST_CLEAR)) begin
            r_mem[r_clr_ptr] <= '0;
        end else if (rst_in && w_wr_en) begin
            r_mem[rsd_addr_in] <= rsd_data_in;
        end
    end

`endif

    // Read port 1: gated by state, enable and x0, then bypass, then array.
    always_comb begin
        w_rd1 = '0;
        if ((r_state == c_ST_READY) && reg1_reador_not && (reg1addr != c_ZERO_ADDR)) begin
            if (write_rsd_in && rdy_in && (rsd_addr_in == reg1addr)) begin
                w_rd1 = rsd_data_in;
            end else begin
                w_rd1 = r_mem[reg1addr];
            end
        end
    end

    // Read port 2: identical priority to port 1.
    always_comb begin
        w_rd2 = '0;
        if ((r_state == c_ST_READY) && reg2_reador_not && (reg2addr != c_ZERO_ADDR)) begin
            if (write_rsd_in && rdy_in && (rsd_addr_in == reg2addr)) begin
                w_rd2 = rsd_data_in;
            end else begin
                w_rd2 = r_mem[reg2addr];
            end
        end
    end

    assign reg1_data      = w_rd1;
    assign reg2_data      = w_rd2;
    assign stall_from_reg = (r_state != c_ST_READY);

endmodule
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile
// Purpose  : Directed, table-driven bench for regfile: reset/clear timing,
//            read gating, x0 handling, bypass, rdy_in gating, reset aborts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile;

`ifdef REGFILE_FAST_INIT_EN
    localparam int c_SWEEP = 0;
    localparam int c_SWEEP_STRETCH = 0;
`else
    localparam int c_SWEEP = 31;
    localparam int c_SWEEP_STRETCH = 35;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        reg1_reador_not;
    logic [4:0]  reg1addr;
    logic [31:0] reg1_data;
    logic        reg2_reador_not;
    logic [4:0]  reg2addr;
    logic [31:0] reg2_data;
    logic        write_rsd_in;
    logic [4:0]  rsd_addr_in;
    logic [31:0] rsd_data_in;
    logic        stall_from_reg;

    int n_checks = 0;
    int n_err    = 0;

    regfile #(.REG_NUM(32), .ADDR_W(5), .DATA_W(32)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .reg1_reador_not (reg1_reador_not),
        .reg1addr        (reg1addr),
        .reg1_data       (reg1_data),
        .reg2_reador_not (reg2_reador_not),
        .reg2addr        (reg2addr),
        .reg2_data       (reg2_data),
        .write_rsd_in    (write_rsd_in),
        .rsd_addr_in     (rsd_addr_in),
        .rsd_data_in     (rsd_data_in),
        .stall_from_reg  (stall_from_reg)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rdy;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        en1;
        logic [4:0]  a1;
        logic        en2;
        logic [4:0]  a2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one edge; inputs change 1 time unit after it.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        rdy_in = 1'b1;
        write_rsd_in = 1'b0; rsd_addr_in = '0; rsd_data_in = '0;
        reg1_reador_not = 1'b1; reg1addr = '0;
        reg2_reador_not = 1'b1; reg2addr = '0;
    endtask

    // Counts stalled edges after the release edge. Optionally drops rdy_in for
    // a window and issues one write at a given stalled cycle.
    task automatic measure_sweep(input int rdy_lo_at, input int rdy_lo_len,
                                 input int wr_at, output int n);
        n = 0;
        while (stall_from_reg && n < 200) begin
            rdy_in = !(n >= rdy_lo_at && n < rdy_lo_at + rdy_lo_len);
            write_rsd_in = (n == wr_at);
            rsd_addr_in  = 5'd3;
            rsd_data_in  = 32'h0000_00AA;
            tick();
            n++;
        end
        idle_inputs();
    endtask

    task automatic do_reset(input int cycles);
        rst_in = 1'b0;
        repeat (cycles) tick();
        rst_in = 1'b1;
        tick();
    endtask

    initial begin
        int n;
        idle_inputs();
        rst_in = 1'b0;

        // Reset held: stall high and reads zero even with a matching write.
        write_rsd_in = 1'b1; rsd_addr_in = 5'd4; rsd_data_in = 32'hFF;
        reg1addr = 5'd4; reg2addr = 5'd4;
        repeat (3) tick();
        #2;
        chk("reset_stall", {31'b0, stall_from_reg}, 32'd1);
        chk("reset_rd1", reg1_data, 32'h0);
        chk("reset_rd2", reg2_data, 32'h0);
        idle_inputs();

        // Release: this edge moves out of RESET.
        rst_in = 1'b1;
        tick();
        measure_sweep(-10, 0, -1, n);
        chk("sweep_len", 32'(n), 32'(c_SWEEP));
        chk("ready_stall", {31'b0, stall_from_reg}, 32'd0);

        //            rdy  we    waddr  wdata          en1   a1     en2   a2     exp1           exp2
        vecs[0]  = '{1'b1, 1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  1'b1, 5'd7,  32'h0,         32'h0};
        vecs[1]  = '{1'b1, 1'b1, 5'd5,  32'hDEADBEEF,  1'b1, 5'd5,  1'b1, 5'd5,  32'hDEADBEEF,  32'hDEADBEEF};
        vecs[2]  = '{1'b1, 1'b0, 5'd0,  32'h0,         1'b1, 5'd5,  1'b1, 5'd5,  32'hDEADBEEF,  32'hDEADBEEF};
        vecs[3]  = '{1'b1, 1'b1, 5'd0,  32'h00001234,  1'b1, 5'd0,  1'b1, 5'd0,  32'h0,         32'h0};
        vecs[4]  = '{1'b1, 1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  1'b1, 5'd0,  32'h0,         32'h0};
        vecs[5]  = '{1'b1, 1'b1, 5'd9,  32'h11,        1'b0, 5'd9,  1'b1, 5'd9,  32'h0,         32'h11};
        vecs[6]  = '{1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 5'd9,  1'b1, 5'd9,  32'h0,         32'h11};
        vecs[7]  = '{1'b1, 1'b1, 5'd7,  32'hA5A5A5A5,  1'b1, 5'd7,  1'b1, 5'd5,  32'hA5A5A5A5,  32'hDEADBEEF};
        vecs[8]  = '{1'b1, 1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  1'b1, 5'd31, 32'hA5A5A5A5,  32'h0};
        vecs[9]  = '{1'b0, 1'b1, 5'd12, 32'hFFFF0000,  1'b1, 5'd12, 1'b1, 5'd12, 32'h0,         32'h0};
        vecs[10] = '{1'b1, 1'b0, 5'd0,  32'h0,         1'b1, 5'd12, 1'b1, 5'd9,  32'h0,         32'h11};
        vecs[11] = '{1'b1, 1'b1, 5'd31, 32'hCAFEF00D,  1'b1, 5'd31, 1'b1, 5'd7,  32'hCAFEF00D,  32'hA5A5A5A5};
        vecs[12] = '{1'b1, 1'b1, 5'd5,  32'h12345678,  1'b1, 5'd5,  1'b1, 5'd5,  32'h12345678,  32'h12345678};
        vecs[13] = '{1'b1, 1'b0, 5'd0,  32'h0,         1'b1, 5'd5,  1'b1, 5'd31, 32'h12345678,  32'hCAFEF00D};

        for (int i = 0; i < 14; i++) begin
            rdy_in = vecs[i].rdy;
            write_rsd_in = vecs[i].we; rsd_addr_in = vecs[i].waddr; rsd_data_in = vecs[i].wdata;
            reg1_reador_not = vecs[i].en1; reg1addr = vecs[i].a1;
            reg2_reador_not = vecs[i].en2; reg2addr = vecs[i].a2;
            #2;
            chk($sformatf("vec%0d_rd1", i), reg1_data, vecs[i].exp1);
            chk($sformatf("vec%0d_rd2", i), reg2_data, vecs[i].exp2);
            tick();
        end
        idle_inputs();

        // Reset while READY forces a full re-clear of previously written data.
        do_reset(2);
        measure_sweep(-10, 0, -1, n);
        chk("reclear_len", 32'(n), 32'(c_SWEEP));
        reg1addr = 5'd5; reg2addr = 5'd31;
        #2;
        chk("reclear_x5", reg1_data, 32'h0);
        chk("reclear_x31", reg2_data, 32'h0);
        idle_inputs();

        // Put data in x3, then abort a sweep at clr_ptr==10 and restart.
        write_rsd_in = 1'b1; rsd_addr_in = 5'd3; rsd_data_in = 32'h5555;
        tick();
        idle_inputs();
        do_reset(1);
        repeat (9) tick();
        rst_in = 1'b0;
        tick();
        #2;
        chk("abort_stall", {31'b0, stall_from_reg}, 32'd1);
        rst_in = 1'b1;
        tick();
        // x3 write attempted well after the sweep passed x3: must not land.
        measure_sweep(-10, 0, 20, n);
        chk("abort_sweep_len", 32'(n), 32'(c_SWEEP));
        reg1addr = 5'd3; reg2addr = 5'd3;
        #2;
        chk("clear_wr_x3_p1", reg1_data, 32'h0);
        chk("clear_wr_x3_p2", reg2_data, 32'h0);
        idle_inputs();

        // rdy_in low for 4 cycles mid-sweep stretches the stall.
        do_reset(2);
        measure_sweep(5, 4, -1, n);
        chk("stretch_len", 32'(n), 32'(c_SWEEP_STRETCH));
        chk("stretch_stall", {31'b0, stall_from_reg}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
